// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes common to the transmitter and receiver,
// and the clocks-per-bit calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4
    } uart_state_t;

    function automatic int calc_cycle(input int clk_fre, input int baud_rate);
        return clk_fre * 1000000 / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; resets to 1 so an idle-high
// line does not produce a spurious edge after reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-edge resynchronisation, mid-bit sampling, valid/ready
// byte output and single-cycle framing/overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FRE   = 50,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    input  logic       rx_data_ready,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam int CYCLE = calc_cycle(CLK_FRE, BAUD_RATE);

    generate
        if (CYCLE < 4 || CYCLE > 65535) begin : g_bad_cycle
            $error("uart_rx: clocks per bit out of range 4..65535");
        end
    endgenerate

    localparam logic [15:0] HALF_LAST = 16'(CYCLE / 2 - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CYCLE - 1);

    logic        rx_sync;
    logic        rx_prev_q;
    logic        falling_edge;
    uart_state_t state_q, state_d;
    logic [15:0] cycle_cnt_q, cycle_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        valid_q, valid_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_pin),
        .q     (rx_sync)
    );

    assign falling_edge = !rx_sync && rx_prev_q;

    always_comb begin
        state_d     = state_q;
        cycle_cnt_d = cycle_cnt_q + 16'd1;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        valid_d     = valid_q && !rx_data_ready;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cycle_cnt_d = '0;
                if (falling_edge) state_d = S_START;
            end
            S_START: begin
                // A high line at mid start bit means the edge was a glitch
                if (cycle_cnt_q == HALF_LAST) state_d = rx_sync ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (cycle_cnt_q == BIT_LAST) begin
                    cycle_cnt_d = '0;
                    shift_d     = {rx_sync, shift_q[7:1]};
                    bit_cnt_d   = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                // Leave mid stop bit so a back-to-back start edge is not missed
                if (cycle_cnt_q == BIT_LAST) begin
                    state_d = S_IDLE;
                    if (!rx_sync) begin
                        frame_err_d = 1'b1;
                    end else if (!valid_q || rx_data_ready) begin
                        rx_data_d = shift_q;
                        valid_d   = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            cycle_cnt_d = '0;
            bit_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev_q   <= 1'b1;
            state_q     <= S_IDLE;
            cycle_cnt_q <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_prev_q   <= rx_sync;
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_data_valid = valid_q;
    assign rx_frame_err  = frame_err_q;
    assign rx_overrun    = overrun_q;

endmodule
